// File: rtl/sm_pkg.sv
// Package for the bytecode fetch sequencer (state_machine).
// Purpose: shared state encoding, width constants, opcode constants and the
//          has_operand() helper used by the opcode length ROM.
// Optional feature macro (consumed by state_machine): STATE_MACHINE_NOP_SKIP_EN.
package sm_pkg;

    localparam int BYTE_BITS   = 8;
    localparam int WIDTH_IN    = BYTE_BITS;
    localparam int WIDTH_OUT   = 2 * BYTE_BITS;
    localparam int MEMORY_SIZE = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FETCH_OP  = 2'd1,
        FETCH_ARG = 2'd2,
        SEND      = 2'd3
    } state_t;

    localparam logic [7:0] OP_NOP      = 8'h00;
    localparam logic [7:0] OP_BIPUSH   = 8'h10;
    localparam logic [7:0] OP_LDC      = 8'h12;
    localparam logic [7:0] OP_XLOAD_LO = 8'h15;
    localparam logic [7:0] OP_XLOAD_HI = 8'h19;
    localparam logic [7:0] OP_XSTOR_LO = 8'h36;
    localparam logic [7:0] OP_XSTOR_HI = 8'h3A;
    localparam logic [7:0] OP_RET      = 8'hA9;
    localparam logic [7:0] OP_NEWARRAY = 8'hBC;

    // True when the opcode is followed by exactly one operand byte.
    function automatic logic has_operand(input logic [7:0] opcode);
        logic result;
        result = 1'b0;
        if (opcode == OP_BIPUSH || opcode == OP_LDC ||
            opcode == OP_RET    || opcode == OP_NEWARRAY)
            result = 1'b1;
        else if (opcode >= OP_XLOAD_LO && opcode <= OP_XLOAD_HI)
            result = 1'b1;
        else if (opcode >= OP_XSTOR_LO && opcode <= OP_XSTOR_HI)
            result = 1'b1;
        return result;
    endfunction

endpackage

// File: rtl/opcode_len_rom.sv
// Purely combinational opcode -> "takes an operand byte" lookup.
// Ports:
//   i_opcode       in   8   opcode byte
//   o_has_operand  out  1   1 when one operand byte follows the opcode
module opcode_len_rom
    import sm_pkg::*;
(
    input  logic [7:0] i_opcode,
    output logic       o_has_operand
);

    assign o_has_operand = sm_pkg::has_operand(i_opcode);

endmodule

// File: rtl/state_machine.sv
// Bytecode fetch sequencer: walks a byte-wide program memory, reads an opcode
// (and its operand byte when it has one), packs {opcode, operand} into a
// 16-bit word and hands it to the decoder with a start/ready handshake.
// Optional feature: STATE_MACHINE_NOP_SKIP_EN -- when defined, nop (0x00)
// opcodes are consumed in FETCH_OP and never sent.
// Ports:
//   clk                 in   1              rising-edge clock
//   reset               in   1              synchronous, active-high
//   ready_from_decoder  in   1              decoder can accept a word
//   start_for_decoder   out  1              word handed over this cycle
//   data_from_memory    in   width_in       byte at memory_pointer (comb read)
//   data_for_decoder    out  width_out      last word handed over (registered)
//   memory_pointer      out  memory_size+1  current fetch address
//   state / next_state  out  2              FSM debug
//   data                out  width_out      assembly register
//   read_opcode / send  out  1              state strobes
module state_machine
    import sm_pkg::*;
#(
    parameter int byte_bits   = BYTE_BITS,
    parameter int width_in    = WIDTH_IN,
    parameter int width_out   = WIDTH_OUT,
    parameter int memory_size = MEMORY_SIZE
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ready_from_decoder,
    output logic                   start_for_decoder,
    input  logic [width_in-1:0]    data_from_memory,
    output logic [width_out-1:0]   data_for_decoder,
    output logic [memory_size:0]   memory_pointer,
    output logic [1:0]             state,
    output logic [1:0]             next_state,
    output logic [width_out-1:0]   data,
    output logic                   read_opcode,
    output logic                   send
);

    localparam logic [memory_size:0] PTR_ONE = {{memory_size{1'b0}}, 1'b1};

    state_t                 r_state;
    state_t                 w_next_state;
    logic [memory_size:0]   r_pointer;
    logic [width_out-1:0]   r_data;
    logic [width_out-1:0]   r_data_for_decoder;
    logic                   w_has_operand;
    logic                   w_is_nop;

    opcode_len_rom u_opcode_len_rom (
        .i_opcode      (data_from_memory[7:0]),
        .o_has_operand (w_has_operand)
    );

`ifdef STATE_MACHINE_NOP_SKIP_EN
    assign w_is_nop = (data_from_memory[7:0] == OP_NOP);
`else
    assign w_is_nop = 1'b0;
`endif

    // State register and data path. The pointer wraps naturally at the top
    // of the address space.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state            <= IDLE;
            r_pointer          <= '0;
            r_data             <= '0;
            r_data_for_decoder <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                FETCH_OP: begin
                    r_pointer <= r_pointer + PTR_ONE;
                    // A skipped nop leaves the assembly register untouched.
                    if (!w_is_nop)
                        r_data <= {data_from_memory, {byte_bits{1'b0}}};
                end
                FETCH_ARG: begin
                    r_pointer                <= r_pointer + PTR_ONE;
                    r_data[byte_bits-1:0]    <= data_from_memory;
                end
                SEND: begin
                    if (ready_from_decoder)
                        r_data_for_decoder <= r_data;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:      if (ready_from_decoder) w_next_state = FETCH_OP;
            FETCH_OP: begin
                if (w_is_nop)
                    w_next_state = FETCH_OP;
                else if (w_has_operand)
                    w_next_state = FETCH_ARG;
                else
                    w_next_state = SEND;
            end
            FETCH_ARG: w_next_state = SEND;
            SEND:      if (ready_from_decoder) w_next_state = FETCH_OP;
            default:   w_next_state = IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        read_opcode       = 1'b0;
        send              = 1'b0;
        start_for_decoder = 1'b0;
        case (r_state)
            FETCH_OP: read_opcode = 1'b1;
            SEND: begin
                send              = 1'b1;
                start_for_decoder = ready_from_decoder;
            end
            default: ;
        endcase
    end

    assign state            = r_state;
    assign next_state       = w_next_state;
    assign data             = r_data;
    assign data_for_decoder = r_data_for_decoder;
    assign memory_pointer   = r_pointer;

endmodule

// File: tb/tb_state_machine.sv
module tb_state_machine;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready_from_decoder;
    logic        start_for_decoder;
    logic [7:0]  data_from_memory;
    logic [15:0] data_for_decoder;
    logic [8:0]  memory_pointer;
    logic [1:0]  state;
    logic [1:0]  next_state;
    logic [15:0] data;
    logic        read_opcode;
    logic        send;

    always #5 clk = ~clk;

    logic [7:0] mem [0:511];
    assign data_from_memory = mem[memory_pointer];

    state_machine dut (
        .clk                (clk),
        .reset              (reset),
        .ready_from_decoder (ready_from_decoder),
        .start_for_decoder  (start_for_decoder),
        .data_from_memory   (data_from_memory),
        .data_for_decoder   (data_for_decoder),
        .memory_pointer     (memory_pointer),
        .state              (state),
        .next_state         (next_state),
        .data               (data),
        .read_opcode        (read_opcode),
        .send               (send)
    );

    typedef struct {
        logic [15:0] word;
        int          bytes;
        logic [8:0]  end_ptr;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_words = 0;

    function automatic bit takes_operand(input logic [7:0] op);
        return op inside {8'h10, 8'h12, [8'h15:8'h19], [8'h36:8'h3A], 8'hA9, 8'hBC};
    endfunction

    // Reference model: the word stream the sequencer must emit when it
    // starts from address 0 over the current memory image.
    task automatic fill_expected();
        int p;
        exp_q.delete();
        p = 0;
        for (int w = 0; w < 1500; w++) begin
            logic [7:0]  op;
            logic [15:0] word;
            int          nb;
            exp_t        e;
            nb = 0;
`ifdef STATE_MACHINE_NOP_SKIP_EN
            while (mem[p] == 8'h00 && nb < 600) begin
                p = (p + 1) % 512;
                nb++;
            end
`endif
            op = mem[p];
            p  = (p + 1) % 512;
            nb++;
            if (takes_operand(op)) begin
                word = {op, mem[p]};
                p    = (p + 1) % 512;
                nb++;
            end else begin
                word = {op, 8'h00};
            end
            e.word    = word;
            e.bytes   = nb;
            e.end_ptr = p[8:0];
            exp_q.push_back(e);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor / scoreboard.
    logic        pend = 1'b0;
    logic [15:0] pend_word;
    bit          have_prev = 1'b0;
    bit          ready_ok  = 1'b1;
    int          cyc       = 0;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (pend) begin
            check("data_for_decoder", {16'h0, data_for_decoder}, {16'h0, pend_word});
            pend = 1'b0;
        end
        if (reset) begin
            have_prev = 1'b0;
            ready_ok  = 1'b1;
            cyc       = 0;
        end else begin
            cyc++;
            if (!ready_from_decoder) ready_ok = 1'b0;
            check("strobes", {29'h0, start_for_decoder, read_opcode, send},
                  {29'h0, (state == 2'd3) && ready_from_decoder, state == 2'd1, state == 2'd3});
            if (start_for_decoder) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("[TB] FAIL underflow: start with no expected word, data=%0h", data);
                end else begin
                    mon_e = exp_q.pop_front();
                    n_words++;
                    $display("[TB] word %0d: data=%04h expected=%04h ptr=%0h", n_words, data, mon_e.word, memory_pointer);
                    check("assembly_word", {16'h0, data}, {16'h0, mon_e.word});
                    check("pointer_at_send", {23'h0, memory_pointer}, {23'h0, mon_e.end_ptr});
                    if (have_prev && ready_ok)
                        check("throughput", cyc, mon_e.bytes + 1);
                    pend      = 1'b1;
                    pend_word = mon_e.word;
                end
                have_prev = 1'b1;
                ready_ok  = 1'b1;
                cyc       = 0;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset              = 1'b1;
        ready_from_decoder = 1'b0;
        fill_expected();
        @(posedge clk);
        @(negedge clk);
        check("reset_state", {30'h0, state}, 32'h0);
        check("reset_pointer", {23'h0, memory_pointer}, 32'h0);
        check("reset_dfd", {16'h0, data_for_decoder}, 32'h0);
        check("reset_data", {16'h0, data}, 32'h0);
        check("reset_start", {31'h0, start_for_decoder}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic run(input int n, input int ready_pct);
        repeat (n) begin
            @(posedge clk);
            #1;
            ready_from_decoder = ($urandom_range(0, 99) < ready_pct);
        end
    endtask

    logic [7:0] op_list [0:13];
    logic [7:0] prefix  [0:9];

    initial begin
        reset              = 1'b1;
        ready_from_decoder = 1'b0;
        op_list = '{8'h10, 8'h12, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19,
                    8'h36, 8'h37, 8'h38, 8'h39, 8'h3A, 8'hA9, 8'hBC};
        prefix  = '{8'h03, 8'h10, 8'h2A, 8'h6F, 8'h91, 8'h50, 8'h00, 8'h04, 8'h15, 8'h00};
        for (int i = 0; i < 512; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 30)      mem[i] = op_list[$urandom_range(0, 13)];
            else if (r < 40) mem[i] = 8'h00;
            else             mem[i] = 8'($urandom);
        end
        for (int i = 0; i < 10; i++) mem[i] = prefix[i];
        mem[511] = 8'h04;

        do_reset();
        run(400, 100);           // ready held high: throughput and wrap
        run(1200, 70);           // randomized backpressure
        for (int k = 0; k < 4; k++) begin
            run($urandom_range(3, 40), 80);
            do_reset();          // reset lands at an arbitrary point of a fetch
            run(150, 75);
        end
        run(5, 100);
        @(negedge clk);
        n_tests++;
        if (n_words < 300) begin
            n_fail++;
            $display("[TB] FAIL progress: got %0d words, required at least 300", n_words);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
